morse_receptor: RTL

- Receive end of the Morse link: samples the serial on/off keying line once per time unit.
- Detects the start of each character and its inter-character gap, and packs each character into the same 27-bit word format the transmitter memory stores: {length[4:0], pattern[21:0]}, first-keyed bit in pattern[0].
- Emits one word per character with a write index 1..12, so the words can load a character register bank directly.

---
 rtl/morse_pkg.sv | 40 ++++
 rtl/morse_ensamblador.sv | 75 +++++++
 rtl/morse_receptor.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared constants and types for the Morse receive path.
// Word format matches the transmitter memory: {longitud[4:0], patron[21:0]},
// first keyed time unit in patron[0].
// The optional word-space feature (macro MORSE_ESPACIO_EN) uses the
// ESPACIO_* constants below.
package morse_pkg;

  localparam int unsigned ANCHO_PATRON     = 22;
  localparam int unsigned ANCHO_LONG       = 5;
  localparam int unsigned MAX_CARAC        = 12;
  localparam int unsigned GAP_LEN          = 3;

  // Total silence, in time units, that marks a word space.
  localparam int unsigned ESPACIO_UNIDADES = 7;
  // Idle zeros still needed after the inter-character gap already counted.
  localparam int unsigned ESPACIO_OCIOSO   = ESPACIO_UNIDADES - GAP_LEN;
  localparam int unsigned ANCHO_OCIO       = 3;

  localparam int unsigned ANCHO_IDX        = 5;
  localparam int unsigned ANCHO_DIR        = 4;
  localparam int unsigned ANCHO_CEROS      = $clog2(GAP_LEN + 1);
  localparam int unsigned ANCHO_PALABRA    = ANCHO_LONG + ANCHO_PATRON;

  typedef enum logic [1:0] {
    StReposo,
    StRecibe,
    StDescarte,
    StEmite
  } estado_e;

  typedef logic [ANCHO_PALABRA-1:0] palabra_t;

  localparam palabra_t PALABRA_ESPACIO = '0;

  function automatic palabra_t empaqueta(input logic [ANCHO_LONG-1:0]   lon,
                                         input logic [ANCHO_PATRON-1:0] pat);
    return {lon, pat};
  endfunction

endpackage

// File: rtl/morse_ensamblador.sv
// Character assembler: accumulates one Morse character bit by bit.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   captura_i     apply bit_i this cycle
//   bit_i         sampled keying value
//   limpiar_i     clear all state; if captura_i is also high, bit_i is applied
//                 on top of the cleared state
//   patron_o      pattern register, first unit in bit 0
//   longitud_o    position just past the last keyed unit (trailing zeros excluded)
//   ceros_o       current run of consecutive zero units (saturates at GAP_LEN)
//   desborde_o    pattern is full; another 1 cannot be stored
module morse_ensamblador
  import morse_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    captura_i,
  input  logic                    bit_i,
  input  logic                    limpiar_i,
  output logic [ANCHO_PATRON-1:0] patron_o,
  output logic [ANCHO_LONG-1:0]   longitud_o,
  output logic [ANCHO_CEROS-1:0]  ceros_o,
  output logic                    desborde_o
);

  logic [ANCHO_PATRON-1:0] patron_q, patron_d;
  logic [ANCHO_IDX-1:0]    idx_q, idx_d;
  logic [ANCHO_LONG-1:0]   ultimo1_q, ultimo1_d;
  logic [ANCHO_CEROS-1:0]  ceros_q, ceros_d;

  always_comb begin
    // Clear first so a capture in the same cycle starts a fresh character.
    patron_d  = limpiar_i ? '0 : patron_q;
    idx_d     = limpiar_i ? '0 : idx_q;
    ultimo1_d = limpiar_i ? '0 : ultimo1_q;
    ceros_d   = limpiar_i ? '0 : ceros_q;
    if (captura_i) begin
      if (bit_i) begin
        ceros_d = '0;
        if (idx_d < ANCHO_IDX'(ANCHO_PATRON)) begin
          patron_d[idx_d] = 1'b1;
          ultimo1_d       = ANCHO_LONG'(idx_d + 1'b1);
          idx_d           = idx_d + 1'b1;
        end
      end else begin
        if (idx_d < ANCHO_IDX'(ANCHO_PATRON)) begin
          idx_d = idx_d + 1'b1;
        end
        if (ceros_d != ANCHO_CEROS'(GAP_LEN)) begin
          ceros_d = ceros_d + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      patron_q  <= '0;
      idx_q     <= '0;
      ultimo1_q <= '0;
      ceros_q   <= '0;
    end else begin
      patron_q  <= patron_d;
      idx_q     <= idx_d;
      ultimo1_q <= ultimo1_d;
      ceros_q   <= ceros_d;
    end
  end

  assign patron_o   = patron_q;
  assign longitud_o = ultimo1_q;
  assign ceros_o    = ceros_q;
  assign desborde_o = (idx_q == ANCHO_IDX'(ANCHO_PATRON));

endmodule

// File: rtl/morse_receptor.sv
// Morse receiver: samples the keying line once per time unit, splits the
// stream into characters on GAP_LEN-unit gaps and emits one packed word per
// character with a write index 1..MAX_CARAC for a character register bank.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   en_muestra   one-cycle strobe per time unit; linea sampled only then
//   linea        received keying (1 = tone on)
//   dato         {longitud, patron}; held until the next emission
//   dato_valido  one-cycle pulse, dato/direccion valid
//   direccion    index of the emitted word
//   conta_carac  words stored so far (saturates at MAX_CARAC)
//   lleno        conta_carac == MAX_CARAC
//   error_ovf    one-cycle pulse, character longer than ANCHO_PATRON dropped
// Build option: define MORSE_ESPACIO_EN to emit an all-zero word-space word
// once ESPACIO_UNIDADES units of silence follow a character.
module morse_receptor
  import morse_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en_muestra,
  input  logic                     linea,
  output logic [ANCHO_PALABRA-1:0] dato,
  output logic                     dato_valido,
  output logic [ANCHO_DIR-1:0]     direccion,
  output logic [ANCHO_DIR-1:0]     conta_carac,
  output logic                     lleno,
  output logic                     error_ovf
);

  estado_e                 estado_q, estado_d;
  palabra_t                dato_q, dato_d;
  logic                    dato_valido_q, dato_valido_d;
  logic [ANCHO_DIR-1:0]    direccion_q, direccion_d;
  logic [ANCHO_DIR-1:0]    conta_q, conta_d;
  logic                    error_ovf_q, error_ovf_d;

  logic                    captura, limpiar, emitir;
  palabra_t                palabra;
  logic [ANCHO_PATRON-1:0] patron;
  logic [ANCHO_LONG-1:0]   longitud;
  logic [ANCHO_CEROS-1:0]  ceros;
  logic                    desborde;
  logic                    lleno_w;
  logic                    fin_gap;

`ifdef MORSE_ESPACIO_EN
  logic                    pend_q, pend_d;
  logic [ANCHO_OCIO-1:0]   ocio_q, ocio_d;
`endif

  morse_ensamblador u_ensamblador (
    .clk_i      (CLK),
    .rst_i      (RST),
    .captura_i  (captura),
    .bit_i      (linea),
    .limpiar_i  (limpiar),
    .patron_o   (patron),
    .longitud_o (longitud),
    .ceros_o    (ceros),
    .desborde_o (desborde)
  );

  assign lleno_w = (conta_q == ANCHO_DIR'(MAX_CARAC));
  // This zero sample completes the gap.
  assign fin_gap = !linea && (ceros == ANCHO_CEROS'(GAP_LEN - 1));

  always_comb begin
    estado_d    = estado_q;
    captura     = 1'b0;
    limpiar     = 1'b0;
    emitir      = 1'b0;
    palabra     = empaqueta(longitud, patron);
    error_ovf_d = 1'b0;

    unique case (estado_q)
      StReposo: begin
        if (en_muestra && linea) begin
          captura  = 1'b1;
          estado_d = StRecibe;
        end
`ifdef MORSE_ESPACIO_EN
        else if (en_muestra && pend_q &&
                 (ocio_q == ANCHO_OCIO'(ESPACIO_OCIOSO - 1))) begin
          emitir   = 1'b1;
          palabra  = PALABRA_ESPACIO;
          estado_d = StEmite;
        end
`endif
      end
      StRecibe: begin
        if (en_muestra) begin
          if (linea && desborde) begin
            error_ovf_d = 1'b1;
            estado_d    = StDescarte;
          end else begin
            captura = 1'b1;
            if (fin_gap) begin
              // A zero never changes patron/longitud, so the current
              // contents are already the finished word.
              emitir   = 1'b1;
              estado_d = StEmite;
            end
          end
        end
      end
      StEmite: begin
        limpiar = 1'b1;
        if (en_muestra && linea) begin
          captura  = 1'b1;
          estado_d = StRecibe;
        end else begin
          estado_d = StReposo;
        end
      end
      StDescarte: begin
        if (en_muestra) begin
          if (fin_gap) begin
            limpiar  = 1'b1;
            estado_d = StReposo;
          end else begin
            // Pattern is full, so only the zero-run counter moves.
            captura = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    dato_d        = dato_q;
    dato_valido_d = 1'b0;
    direccion_d   = direccion_q;
    conta_d       = conta_q;
    if (emitir && !lleno_w) begin
      dato_d        = palabra;
      dato_valido_d = 1'b1;
      direccion_d   = conta_q + 1'b1;
      conta_d       = conta_q + 1'b1;
    end
  end

`ifdef MORSE_ESPACIO_EN
  // Count silence after a character; arm once per silence run.
  always_comb begin
    pend_d = pend_q;
    ocio_d = ocio_q;
    if (estado_q == StRecibe && emitir) begin
      pend_d = 1'b1;
      ocio_d = '0;
    end else if (estado_q == StEmite && captura) begin
      pend_d = 1'b0;
      ocio_d = '0;
    end else if (estado_q == StReposo && en_muestra) begin
      if (linea || emitir) begin
        pend_d = 1'b0;
        ocio_d = '0;
      end else if (pend_q) begin
        ocio_d = ocio_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q <= 1'b0;
      ocio_q <= '0;
    end else begin
      pend_q <= pend_d;
      ocio_q <= ocio_d;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      estado_q      <= StReposo;
      dato_q        <= '0;
      dato_valido_q <= 1'b0;
      direccion_q   <= '0;
      conta_q       <= '0;
      error_ovf_q   <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      dato_q        <= dato_d;
      dato_valido_q <= dato_valido_d;
      direccion_q   <= direccion_d;
      conta_q       <= conta_d;
      error_ovf_q   <= error_ovf_d;
    end
  end

  assign dato        = dato_q;
  assign dato_valido = dato_valido_q;
  assign direccion   = direccion_q;
  assign conta_carac = conta_q;
  assign lleno       = lleno_w;
  assign error_ovf   = error_ovf_q;

endmodule
